// File: rtl/bram_rd_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bram_rd_pkg                                               |
// | Purpose  : shared FSM states and output-buffer constants for the     |
// |            BRAM stream reader.                                       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package bram_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage
`default_nettype wire

// File: rtl/rd_skid_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rd_skid_fifo                                              |
// | Purpose  : small power-of-two FIFO with occupancy count; the head    |
// |            entry is presented combinationally on pop_data.           |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module rd_skid_fifo
  import bram_rd_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = $clog2(DEPTH + 1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_full    = c_cnt_w'(DEPTH);

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_push_ok;
  logic               w_pop_ok;

  assign w_push_ok = push && (r_count != c_full);
  assign w_pop_ok  = pop && (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop_ok) r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  assign pop_data = r_mem[r_rd_ptr];
  assign count    = r_count;
  assign empty    = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/bram_stream_reader.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bram_stream_reader                                        |
// | Purpose  : turns (base, len) commands into BRAM reads and a          |
// |            back-pressured output stream. Optional m_last output is   |
// |            enabled by defining BRAM_RD_LAST_EN.                      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module bram_stream_reader
  import bram_rd_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W:0]   cmd_len,
  output logic [ADDR_W-1:0] r_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              busy,
  output logic              done
`ifdef BRAM_RD_LAST_EN
  ,
  output logic              m_last
`endif
);

`ifdef BRAM_RD_LAST_EN
  localparam int c_fifo_w = DATA_W + 1;
`else
  localparam int c_fifo_w = DATA_W;
`endif
  localparam int c_occ_w = FIFO_CNT_W + 1;
  localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);
  localparam logic [ADDR_W:0]   c_len_one  = (ADDR_W + 1)'(1);

  rd_state_t           r_state;
  rd_state_t           w_state_nxt;
  logic                r_done;
  logic                w_done_nxt;
  logic [ADDR_W-1:0]   r_next_addr;
  logic [ADDR_W:0]     r_remain;
  logic                r_v1;
  logic                r_v2;
  logic                w_start;
  logic                w_issue;
  logic                w_last_issue;
  logic                w_drain_done;
  logic                w_pop;
  logic                w_empty;
  logic [FIFO_CNT_W-1:0] w_count;
  logic [c_occ_w-1:0]  w_occ;
  logic [c_occ_w-1:0]  w_lim;
  logic [c_fifo_w-1:0] w_push_data;
  logic [c_fifo_w-1:0] w_head;

  // Credit check: buffered + in-flight words must leave room, a same-cycle pop frees one.
  assign w_occ        = c_occ_w'(w_count) + c_occ_w'(r_v1) + c_occ_w'(r_v2);
  assign w_lim        = c_occ_w'(FIFO_DEPTH) + c_occ_w'(w_pop);
  assign w_start      = (r_state == IDLE) && cmd_valid && (cmd_len != '0);
  assign w_issue      = (r_state == RUN) && (w_occ < w_lim);
  assign w_last_issue = w_issue && (r_remain == c_len_one);
  assign w_drain_done = (r_state == DRAIN) && !r_v1 && !r_v2 && w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    cmd_ready   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_len == '0) w_done_nxt  = 1'b1;
          else               w_state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_last_issue) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (w_drain_done) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Two-stage read pipeline: address on r_addr, then BRAM data, then FIFO push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_next_addr <= '0;
      r_remain    <= '0;
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
    end else begin
      if (w_start) begin
        r_next_addr <= cmd_base;
        r_remain    <= cmd_len;
      end else if (w_issue) begin
        r_addr      <= r_next_addr;
        r_next_addr <= r_next_addr + c_addr_one;
        r_remain    <= r_remain - c_len_one;
      end
      r_v1 <= w_issue;
      r_v2 <= r_v1;
    end
  end

`ifdef BRAM_RD_LAST_EN
  logic r_l1;
  logic r_l2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_l1 <= 1'b0;
      r_l2 <= 1'b0;
    end else begin
      r_l1 <= w_last_issue;
      r_l2 <= r_l1;
    end
  end

  assign w_push_data = {r_l2, bram_dout};
  assign m_data      = w_head[DATA_W-1:0];
  assign m_last      = w_head[DATA_W];
`else
  assign w_push_data = bram_dout;
  assign m_data      = w_head;
`endif

  assign m_valid = !w_empty;
  assign w_pop   = m_valid && m_ready;
  assign done    = r_done;

  rd_skid_fifo #(
    .DATA_W (c_fifo_w),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (r_v2),
    .push_data (w_push_data),
    .pop       (w_pop),
    .pop_data  (w_head),
    .count     (w_count),
    .empty     (w_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_bram_stream_reader                                     |
// | Purpose  : self-checking bench for bram_stream_reader against a      |
// |            memory-array model; covers m_last when BRAM_RD_LAST_EN.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_bram_stream_reader;

  localparam int DEPTH = 1024;

  typedef struct {
    logic [9:0] base;
    int         len;
    int         stall;
    bit         rnd;
    bit         addr_chk;
    int         exp_beats;
    int         exp_lat;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [9:0] cmd_base = '0;
  logic [10:0] cmd_len = '0;
  logic [9:0] r_addr;
  logic [7:0] bram_dout = '0;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic [7:0] m_data;
  logic       busy;
  logic       done;
`ifdef BRAM_RD_LAST_EN
  logic       m_last;
`endif

  logic [7:0] mem [DEPTH];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         last_addr = 0;

  logic [7:0] beat_q [$];
  bit         last_q [$];
  int         vrise_q [$];
  int         done_q [$];
  int         stall_viol = 0;
  int         max_cnt = 0;
  logic       prev_v = 1'b0;
  logic       prev_r = 1'b0;
  logic [7:0] prev_d = '0;

  vec_t tbl [8];

  bram_stream_reader #(.DATA_W(8), .ADDR_W(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_base  (cmd_base),
    .cmd_len   (cmd_len),
    .r_addr    (r_addr),
    .bram_dout (bram_dout),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .busy      (busy),
    .done      (done)
`ifdef BRAM_RD_LAST_EN
    ,
    .m_last    (m_last)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read BRAM model.
  always @(posedge clk) bram_dout <= mem[r_addr];

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid && !prev_v) vrise_q.push_back(cyc);
      if (prev_v && !prev_r && (!m_valid || m_data !== prev_d)) stall_viol <= stall_viol + 1;
      if (m_valid && m_ready) begin
        beat_q.push_back(m_data);
`ifdef BRAM_RD_LAST_EN
        last_q.push_back(m_last);
`endif
      end
      if (done) done_q.push_back(cyc);
      if (int'(dut.w_count) > max_cnt) max_cnt <= int'(dut.w_count);
      prev_v <= m_valid;
      prev_r <= m_ready;
      prev_d <= m_data;
    end else begin
      prev_v <= 1'b0;
      prev_r <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic run_cmd(input vec_t v);
    int b0, v0, d0, s0, acc, t, n, bad, ones;
    logic [9:0] addrs [$];
    b0 = beat_q.size();
    v0 = vrise_q.size();
    d0 = done_q.size();
    s0 = stall_viol;
    chk("cmd_ready_idle", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_base  = v.base;
    cmd_len   = 11'(v.len);
    m_ready   = (v.stall == 0);
    @(posedge clk); #1;
    acc = cyc;
    cmd_valid = 1'b0;
    t = 0;
    while (done_q.size() == d0 && t < 8000) begin
      if (t >= 1 && t <= v.len) addrs.push_back(r_addr);
      if (v.rnd) m_ready = ($urandom_range(0, 3) != 0);
      else       m_ready = (t >= v.stall);
      @(posedge clk); #1;
      t++;
    end
    m_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("done_seen", 32'(done_q.size() > d0), 1);
    chk("done_count", 32'(done_q.size() - d0), 1);
    n = beat_q.size() - b0;
    chk("beat_count", 32'(n), 32'(v.exp_beats));
    bad = 0;
    for (int i = 0; i < n && i < v.len; i++)
      if (beat_q[b0+i] !== mem[(int'(v.base) + i) % DEPTH]) bad++;
    chk("beat_data_bad", 32'(bad), 0);
    chk("stream_hold_viol", 32'(stall_viol - s0), 0);
    if (v.exp_lat >= 0) begin
      chk("first_valid_lat", (vrise_q.size() > v0) ? 32'(vrise_q[v0] - acc) : 32'hFFFF_FFFF,
          32'(v.exp_lat));
    end else begin
      chk("no_valid", 32'(vrise_q.size() - v0), 0);
      chk("done_after_accept", (done_q.size() > d0) ? 32'(done_q[d0] - acc) : 32'hFFFF_FFFF, 0);
      chk("addr_hold", 32'(r_addr), 32'(last_addr));
    end
    if (v.addr_chk) begin
      chk("addr_seq_len", 32'(addrs.size()), 32'(v.len));
      bad = 0;
      for (int i = 0; i < addrs.size(); i++)
        if (int'(addrs[i]) != (int'(v.base) + i) % DEPTH) bad++;
      chk("addr_seq_bad", 32'(bad), 0);
    end
`ifdef BRAM_RD_LAST_EN
    ones = 0;
    for (int i = 0; i < n; i++) if (last_q[b0+i]) ones++;
    chk("last_count", 32'(ones), (v.len > 0) ? 32'd1 : 32'd0);
    if (n > 0) chk("last_on_final", 32'(last_q[b0+n-1]), 1);
`else
    ones = 0;
`endif
    if (v.len > 0) last_addr = (int'(v.base) + v.len - 1) % DEPTH;
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: got cycle %0d required finish earlier", cyc);
    $fatal(1);
  end

  initial begin
    vec_t rv;
    int b0, d0, t;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);

    tbl[0] = '{base: 10'h010, len: 4,    stall: 0,  rnd: 0, addr_chk: 1, exp_beats: 4,    exp_lat: 3};
    tbl[1] = '{base: 10'h3FE, len: 4,    stall: 0,  rnd: 0, addr_chk: 1, exp_beats: 4,    exp_lat: 3};
    tbl[2] = '{base: 10'h040, len: 16,   stall: 10, rnd: 0, addr_chk: 0, exp_beats: 16,   exp_lat: 3};
    tbl[3] = '{base: 10'h123, len: 0,    stall: 0,  rnd: 0, addr_chk: 0, exp_beats: 0,    exp_lat: -1};
    tbl[4] = '{base: 10'h3FF, len: 1,    stall: 0,  rnd: 0, addr_chk: 1, exp_beats: 1,    exp_lat: 3};
    tbl[5] = '{base: 10'h100, len: 3,    stall: 0,  rnd: 0, addr_chk: 1, exp_beats: 3,    exp_lat: 3};
    tbl[6] = '{base: 10'h200, len: 1024, stall: 0,  rnd: 0, addr_chk: 0, exp_beats: 1024, exp_lat: 3};
    tbl[7] = '{base: 10'h2AB, len: 7,    stall: 3,  rnd: 0, addr_chk: 0, exp_beats: 7,    exp_lat: 3};

    #12;
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_r_addr", 32'(r_addr), 0);
    chk("rst_m_data", 32'(m_data), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_cmd(tbl[i]);

    // Reset in the middle of a long command.
    b0 = beat_q.size();
    d0 = done_q.size();
    cmd_valid = 1'b1;
    cmd_base  = 10'h050;
    cmd_len   = 11'd20;
    m_ready   = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    t = 0;
    while (beat_q.size() - b0 < 5 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("mid_beats_before_reset", 32'(beat_q.size() - b0 >= 5), 1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_m_valid", 32'(m_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("mid_rst_no_done", 32'(done_q.size() - d0), 0);
    chk("mid_rst_idle_valid", 32'(m_valid), 0);
    last_addr = 0;
    rv = '{base: 10'h060, len: 2, stall: 0, rnd: 0, addr_chk: 1, exp_beats: 2, exp_lat: 3};
    run_cmd(rv);

    // Randomized commands with random back-pressure.
    for (int k = 0; k < 30; k++) begin
      rv.base      = 10'($urandom_range(0, DEPTH - 1));
      rv.len       = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
      rv.stall     = 0;
      rv.rnd       = 1;
      rv.addr_chk  = 0;
      rv.exp_beats = rv.len;
      rv.exp_lat   = (rv.len > 0) ? 3 : -1;
      run_cmd(rv);
    end

    chk("fifo_count_max_le4", 32'(max_cnt <= 4), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
